counter_step_arbiter: RTL and testbench

Front-end controller for the single-digit up/down BCD counter on the DE1-SoC. It synchronizes and debounces the raw active-low count-up and count-down push buttons and turns each press into a pending request. It then arbitrates the two requesters onto one step-command channel with a valid/ready handshake, which the counter datapath consumes as one increment or decrement per accepted command.

---
 rtl/counter_step_arbiter.sv | 159 +++++++++++++++
 tb/tb_counter_step_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_step_arbiter.sv
// Key front end for the BCD up/down counter: synchronize, debounce, latch presses, arbitrate onto a step channel.
// Optional hold-to-repeat is enabled with `define COUNTER_AUTO_REPEAT_EN.
module counter_step_arbiter #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_up_n,
    input  logic key_dn_n,
    input  logic step_ready,
    output logic step_valid,
    output logic step_dir,
    output logic up_pending,
    output logic dn_pending,
    output logic last_grant
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       valid_nxt;
    logic       dir_nxt;
    logic       grant_nxt;
    logic       handshake;
    logic [1:0] key_n;
    logic [1:0] set_req;

    // Repeat timing assumes the period fits inside the initial delay.
    if ((REPEAT_PERIOD == 0) || (REPEAT_PERIOD > REPEAT_DELAY)) begin : g_repeat_cfg_check
        $error("counter_step_arbiter: REPEAT_PERIOD must be in 1..REPEAT_DELAY");
    end

    // Bit 1 is the up key, bit 0 the down key.
    assign key_n = {key_up_n, key_dn_n};

    for (genvar k = 0; k < 2; k++) begin : g_key
        logic            sync1;
        logic            sync2;
        logic            db;
        logic            db_d;
        logic [DB_W-1:0] db_cnt;
        logic            press;

        // db only moves after the synchronized level has disagreed for DEBOUNCE_CYCLES counted cycles.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1  <= 1'b1;
                sync2  <= 1'b1;
                db     <= 1'b1;
                db_d   <= 1'b1;
                db_cnt <= '0;
            end else begin
                sync1 <= key_n[k];
                sync2 <= sync1;
                db_d  <= db;
                if (sync2 == db) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
                    db     <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end

        assign press = db_d & ~db;

`ifdef COUNTER_AUTO_REPEAT_EN
        localparam int unsigned HOLD_W = $clog2(REPEAT_DELAY + 1);

        logic [HOLD_W-1:0] hold_cnt;
        logic              repeat_hit;

        assign repeat_hit = ~db && (hold_cnt == HOLD_W'(REPEAT_DELAY));

        // Reloading below the threshold spaces later repeats REPEAT_PERIOD cycles apart.
        always_ff @(posedge clk) begin
            if (rst || db) begin
                hold_cnt <= '0;
            end else if (repeat_hit) begin
                hold_cnt <= HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
            end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end

        assign set_req[k] = press | repeat_hit;
`else
        assign set_req[k] = press;
`endif
    end

    assign handshake = step_valid & step_ready;

    // One-deep request flags; a new request on the clearing cycle survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            up_pending <= 1'b0;
            dn_pending <= 1'b0;
        end else begin
            up_pending <= set_req[1] | (up_pending & ~(handshake & step_dir));
            dn_pending <= set_req[0] | (dn_pending & ~(handshake & ~step_dir));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            step_valid <= 1'b0;
            step_dir   <= 1'b0;
            last_grant <= 1'b0;
        end else begin
            state      <= state_nxt;
            step_valid <= valid_nxt;
            step_dir   <= dir_nxt;
            last_grant <= grant_nxt;
        end
    end

    // Both pending: grant the direction opposite to the last accepted step.
    always_comb begin
        state_nxt = state;
        valid_nxt = step_valid;
        dir_nxt   = step_dir;
        grant_nxt = last_grant;
        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (up_pending || dn_pending) begin
                    state_nxt = ISSUE;
                    valid_nxt = 1'b1;
                    dir_nxt   = (up_pending && dn_pending) ? ~last_grant : up_pending;
                end
            end
            ISSUE: begin
                valid_nxt = 1'b1;
                if (step_ready) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    grant_nxt = step_dir;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_counter_step_arbiter.sv
// Scoreboard bench for counter_step_arbiter: expected step directions are queued at stimulus time
// and compared when a handshake is seen.
module tb_counter_step_arbiter;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 8;

    logic clk = 1'b0;
    logic rst;
    logic key_up_n;
    logic key_dn_n;
    logic step_ready;
    logic step_valid;
    logic step_dir;
    logic up_pending;
    logic dn_pending;
    logic last_grant;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_steps  = 0;
    bit   exp_q[$];

    counter_step_arbiter #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_up_n  (key_up_n),
        .key_dn_n  (key_dn_n),
        .step_ready(step_ready),
        .step_valid(step_valid),
        .step_dir  (step_dir),
        .up_pending(up_pending),
        .dn_pending(dn_pending),
        .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (step_valid) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        if (!seen) check("valid_timeout", 32'd0, 32'd1);
    endtask

    // Handshake will complete on the next rising edge.
    always @(negedge clk) begin
        if (!rst && step_valid && step_ready) begin
            n_steps++;
            if (exp_q.size() == 0) begin
                check("unexpected_step", 32'd1, 32'd0);
            end else begin
                check("step_dir", 32'(step_dir), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst        = 1'b1;
        key_up_n   = 1'b1;
        key_dn_n   = 1'b1;
        step_ready = 1'b1;
        tick(3);
        check("rst_valid", 32'(step_valid), 32'd0);
        check("rst_dir",   32'(step_dir),   32'd0);
        check("rst_uppend", 32'(up_pending), 32'd0);
        check("rst_dnpend", 32'(dn_pending), 32'd0);
        check("rst_grant", 32'(last_grant), 32'd0);
        rst = 1'b0;
        tick(2);

        // Single up press: pending at edge 7, valid at edge 8, handshake at edge 9.
        base = n_steps;
        key_up_n = 1'b0;
        exp_q.push_back(1'b1);
        tick(7);
        check("t1_pend_e6", 32'(up_pending), 32'd0);
        tick(1);
        check("t1_pend_e7", 32'(up_pending), 32'd1);
        check("t1_valid_e7", 32'(step_valid), 32'd0);
        tick(1);
        check("t1_valid_e8", 32'(step_valid), 32'd1);
        check("t1_dir_e8", 32'(step_dir), 32'd1);
        tick(1);
        check("t1_valid_e9", 32'(step_valid), 32'd0);
        check("t1_grant_e9", 32'(last_grant), 32'd1);
        check("t1_pend_e9", 32'(up_pending), 32'd0);
        tick(6);
        key_up_n = 1'b1;
        tick(20);
        check("t1_steps", 32'(n_steps - base), 32'd1);

        // Bounce on the down key never lasts long enough to register.
        base = n_steps;
        for (int i = 0; i < 6; i++) begin
            key_dn_n = 1'b0;
            tick(3);
            key_dn_n = 1'b1;
            tick(1);
        end
        tick(20);
        check("t2_dnpend", 32'(dn_pending), 32'd0);
        check("t2_steps", 32'(n_steps - base), 32'd0);

        // Simultaneous press after reset: up first, then down.
        do_reset();
        base = n_steps;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        key_up_n = 1'b0;
        key_dn_n = 1'b0;
        tick(10);
        check("t3_grant_mid", 32'(last_grant), 32'd1);
        check("t3_dnpend_mid", 32'(dn_pending), 32'd1);
        check("t3_uppend_mid", 32'(up_pending), 32'd0);
        tick(4);
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        tick(20);
        check("t3_grant_end", 32'(last_grant), 32'd0);
        check("t3_pend_end", 32'({up_pending, dn_pending}), 32'd0);
        check("t3_steps", 32'(n_steps - base), 32'd2);

        // Backpressure: command holds steady and a second press is dropped.
        base = n_steps;
        step_ready = 1'b0;
        key_up_n = 1'b0;
        exp_q.push_back(1'b1);
        wait_valid(20);
        key_up_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (i == 8) key_up_n = 1'b0;
            tick(1);
            check("t4_hold_valid", 32'(step_valid), 32'd1);
            check("t4_hold_dir", 32'(step_dir), 32'd1);
        end
        check("t4_uppend", 32'(up_pending), 32'd1);
        step_ready = 1'b1;
        tick(1);
        check("t4_valid_after", 32'(step_valid), 32'd0);
        check("t4_pend_after", 32'(up_pending), 32'd0);
        key_up_n = 1'b1;
        tick(20);
        check("t4_steps", 32'(n_steps - base), 32'd1);

        // Reset during ISSUE drops the command.
        base = n_steps;
        step_ready = 1'b0;
        key_up_n = 1'b0;
        wait_valid(20);
        key_up_n = 1'b1;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_valid", 32'(step_valid), 32'd0);
        check("t5_pend", 32'({up_pending, dn_pending}), 32'd0);
        check("t5_grant", 32'(last_grant), 32'd0);
        step_ready = 1'b1;
        tick(20);
        check("t5_steps", 32'(n_steps - base), 32'd0);

        // Key held through reset yields exactly one press after release.
        base = n_steps;
        key_dn_n = 1'b0;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        exp_q.push_back(1'b0);
        tick(14);
        key_dn_n = 1'b1;
        tick(15);
        check("t6_steps", 32'(n_steps - base), 32'd1);
        check("t6_dnpend", 32'(dn_pending), 32'd0);

        // Long hold: one step, or press plus repeats at +20, +28, ... with auto-repeat.
        do_reset();
        base = n_steps;
        key_up_n = 1'b0;
`ifdef COUNTER_AUTO_REPEAT_EN
        for (int i = 0; i < 6; i++) exp_q.push_back(1'b1);
`else
        exp_q.push_back(1'b1);
`endif
        tick(60);
        key_up_n = 1'b1;
        tick(30);
`ifdef COUNTER_AUTO_REPEAT_EN
        check("t7_steps", 32'(n_steps - base), 32'd6);
`else
        check("t7_steps", 32'(n_steps - base), 32'd1);
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
